// File: rtl/selten_pkg.sv
// rtl/selten_pkg.sv - shared SELTEN datapath widths and load/store unit state encoding
package selten_pkg;
   localparam int DATA_W            = 19;
   localparam int ADDR_W            = 19;
   localparam int MEM_DEPTH_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and Memory_Interface bus of the load/store unit
interface load_store_unit_if;
   import selten_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_error;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req_valid, req_is_store, req_addr, req_wdata, resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_read, mem_write, mem_address, mem_write_data
   );

   modport master (
      output req_valid, req_is_store, req_addr, req_wdata, resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_read, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage sequencer: one load/store at a time onto a single-ported memory
module load_store_unit
   import selten_pkg::*;
#(
   parameter int MEM_DEPTH    = MEM_DEPTH_DEFAULT,
   parameter int READ_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   lsu,
   output logic               busy
);

   localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(MEM_DEPTH);
   localparam logic [3:0]        CNT_LOAD = 4'(READ_LATENCY - 1);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_error_q, resp_error_d;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_error_d = resp_error_q;

      unique case (state_q)
         IDLE: begin
            if (lsu.req_valid) begin
               addr_d  = lsu.req_addr;
               wdata_d = lsu.req_wdata;
               if (lsu.req_addr >= DEPTH) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  rdata_d      = '0;
               end else if (lsu.req_is_store) begin
                  state_d     = WRITE;
                  mem_write_d = 1'b1;
               end else begin
                  state_d    = READ;
                  mem_read_d = 1'b1;
                  cnt_d      = CNT_LOAD;
               end
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            rdata_d      = '0;
         end
         READ: begin
            // Data is sampled on the edge that ends the last mem_read cycle.
            if (cnt_q == 4'd0) begin
               state_d      = RESP;
               rdata_d      = lsu.mem_read_data;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b0;
            end else begin
               cnt_d      = cnt_q - 4'd1;
               mem_read_d = 1'b1;
            end
         end
         RESP: begin
            if (lsu.resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_error_d = 1'b0;
               rdata_d      = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
      end
   end

   // The bus is zeroed whenever no strobe is active so idle cycles never leak stale values.
   assign lsu.mem_read       = mem_read_q;
   assign lsu.mem_write      = mem_write_q;
   assign lsu.mem_address    = (mem_read_q || mem_write_q) ? addr_q : '0;
   assign lsu.mem_write_data = mem_write_q ? wdata_q : '0;
   assign lsu.req_ready      = (state_q == IDLE);
   assign lsu.resp_valid     = resp_valid_q;
   assign lsu.resp_rdata     = rdata_q;
   assign lsu.resp_error     = resp_error_q;
   assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit at read latency 1 and 3
module tb_load_store_unit;
   import selten_pkg::*;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      int                cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if a_if ();
   load_store_unit_if b_if ();
   logic busy_a, busy_b;

   load_store_unit #(.MEM_DEPTH(1024), .READ_LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .lsu(a_if), .busy(busy_a));
   load_store_unit #(.MEM_DEPTH(1024), .READ_LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .lsu(b_if), .busy(busy_b));

   logic [DATA_W-1:0] mem_a [1024];
   logic [DATA_W-1:0] mem_b [1024];
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
   end
   assign a_if.mem_read_data = a_if.mem_read ? mem_a[a_if.mem_address[9:0]] : '0;
   assign b_if.mem_read_data = b_if.mem_read ? mem_b[b_if.mem_address[9:0]] : '0;
   always @(posedge clk) if (a_if.mem_write) mem_a[a_if.mem_address[9:0]] <= a_if.mem_write_data;
   always @(posedge clk) if (b_if.mem_write) mem_b[b_if.mem_address[9:0]] <= b_if.mem_write_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q_a[$];
   exp_t q_b[$];
   logic prev_v [2];
   int   wr_cnt [2];
   int   rd_cnt [2];
   logic [ADDR_W-1:0] last_wr_addr [2];
   logic [DATA_W-1:0] last_wr_data [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int sel, input logic v, input logic rdy, input logic rq_rdy,
                      input logic [DATA_W-1:0] rd, input logic er);
      exp_t e;
      int   qs;
      qs = (sel == 0) ? q_a.size() : q_b.size();
      if (!v) begin
         prev_v[sel] = 1'b0;
      end else if (qs == 0) begin
         chk("resp_unexpected", 32'(v), 32'd0);
      end else begin
         e = (sel == 0) ? q_a[0] : q_b[0];
         if (!prev_v[sel]) chk("resp_latency", 32'(cyc), 32'(e.cyc));
         chk("resp_rdata", 32'(rd), 32'(e.rdata));
         chk("resp_error", 32'(er), 32'(e.err));
         chk("req_ready_in_resp", 32'(rq_rdy), 32'd0);
         prev_v[sel] = 1'b1;
         if (rdy) begin
            if (sel == 0) void'(q_a.pop_front());
            else          void'(q_b.pop_front());
            prev_v[sel] = 1'b0;
         end
      end
   endtask

   task automatic strobe(input int sel, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
      chk("strobe_exclusive", 32'(rd & wr), 32'd0);
      if (!rd && !wr) begin
         chk("idle_address_zero", 32'(ad), 32'd0);
         chk("idle_wdata_zero", 32'(wd), 32'd0);
      end
      if (wr) begin
         wr_cnt[sel]++;
         last_wr_addr[sel] = ad;
         last_wr_data[sel] = wd;
      end
      if (rd) rd_cnt[sel]++;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, a_if.resp_valid, a_if.resp_ready, a_if.req_ready, a_if.resp_rdata, a_if.resp_error);
         mon(1, b_if.resp_valid, b_if.resp_ready, b_if.req_ready, b_if.resp_rdata, b_if.resp_error);
         strobe(0, a_if.mem_read, a_if.mem_write, a_if.mem_address, a_if.mem_write_data);
         strobe(1, b_if.mem_read, b_if.mem_write, b_if.mem_address, b_if.mem_write_data);
      end else begin
         prev_v[0] = 1'b0;
         prev_v[1] = 1'b0;
      end
   end

   // lat: cycles from the cycle after acceptance until resp_valid (store 1, load READ_LATENCY, error 0)
   task automatic issue(input int sel, input logic st, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                        input logic exp_err, input int lat);
      exp_t e;
      int   waited;
      logic rdy;
      waited = 0;
      @(negedge clk);
      rdy = (sel == 0) ? a_if.req_ready : b_if.req_ready;
      while (!rdy && waited < 50) begin
         @(negedge clk);
         waited++;
         rdy = (sel == 0) ? a_if.req_ready : b_if.req_ready;
      end
      chk("req_ready_before_accept", 32'(rdy), 32'd1);
      if (sel == 0) begin
         a_if.req_valid = 1'b1; a_if.req_is_store = st; a_if.req_addr = addr; a_if.req_wdata = wd;
      end else begin
         b_if.req_valid = 1'b1; b_if.req_is_store = st; b_if.req_addr = addr; b_if.req_wdata = wd;
      end
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + 1 + lat;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      @(posedge clk);
      #1;
      if (sel == 0) a_if.req_valid = 1'b0;
      else          b_if.req_valid = 1'b0;
   endtask

   task automatic drain(input int sel);
      int waited;
      int qs;
      logic v;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
         qs = (sel == 0) ? q_a.size() : q_b.size();
         v  = (sel == 0) ? a_if.resp_valid : b_if.resp_valid;
      end while ((qs != 0 || v) && waited < 100);
      if (waited >= 100) chk("drain_timeout", 32'(qs), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, w1, r1, waited;
      logic v;
      a_if.req_valid = 1'b0; a_if.req_is_store = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
      b_if.req_valid = 1'b0; b_if.req_is_store = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0;
      a_if.resp_ready = 1'b1;
      b_if.resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         prev_v[i] = 1'b0; wr_cnt[i] = 0; rd_cnt[i] = 0;
         last_wr_addr[i] = '0; last_wr_data[i] = '0;
      end

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(a_if.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
      chk("rst_mem_read", 32'(a_if.mem_read), 32'd0);
      chk("rst_mem_write", 32'(a_if.mem_write), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_mem_address", 32'(a_if.mem_address), 32'd0);
      chk("rst_resp_rdata", 32'(b_if.resp_rdata), 32'd0);
      rst_n = 1'b1;

      // store addr 2
      w0 = wr_cnt[0];
      issue(0, 1'b1, 19'd2, 19'h01A2B, 19'h0, 1'b0, 1);
      drain(0);
      chk("t1_write_cycles", 32'(wr_cnt[0] - w0), 32'd1);
      chk("t1_write_addr", 32'(last_wr_addr[0]), 32'h00002);
      chk("t1_write_data", 32'(last_wr_data[0]), 32'h01A2B);

      // load addr 2, latency 1
      r0 = rd_cnt[0];
      issue(0, 1'b0, 19'd2, 19'h0, 19'h01A2B, 1'b0, 1);
      drain(0);
      chk("t2_read_cycles", 32'(rd_cnt[0] - r0), 32'd1);

      // back-to-back store then load on the latency-3 unit
      r1 = rd_cnt[1];
      w1 = wr_cnt[1];
      issue(1, 1'b1, 19'd3, 19'h03F4E, 19'h0, 1'b0, 1);
      issue(1, 1'b0, 19'd3, 19'h0, 19'h03F4E, 1'b0, 3);
      drain(1);
      chk("t3_read_cycles", 32'(rd_cnt[1] - r1), 32'd3);
      chk("t3_write_cycles", 32'(wr_cnt[1] - w1), 32'd1);

      // out-of-range load
      r0 = rd_cnt[0];
      w0 = wr_cnt[0];
      issue(0, 1'b0, 19'h7FFFF, 19'h0, 19'h0, 1'b1, 0);
      drain(0);
      chk("t4_no_read", 32'(rd_cnt[0] - r0), 32'd0);
      chk("t4_no_write", 32'(wr_cnt[0] - w0), 32'd0);

      // response back-pressure
      @(posedge clk);
      #1;
      a_if.resp_ready = 1'b0;
      issue(0, 1'b0, 19'd2, 19'h0, 19'h01A2B, 1'b0, 1);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
         v = a_if.resp_valid;
      end while (!v && waited < 20);
      chk("t5_resp_seen", 32'(v), 32'd1);
      chk("t5_busy", 32'(busy_a), 32'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("t5_still_pending", 32'(q_a.size()), 32'd1);
      a_if.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_valid_drop", 32'(a_if.resp_valid), 32'd0);
      chk("t5_popped", 32'(q_a.size()), 32'd0);

      // reset during READ
      issue(1, 1'b0, 19'd3, 19'h0, 19'h03F4E, 1'b0, 3);
      #2;
      chk("t6_read_active", 32'(b_if.mem_read), 32'd1);
      chk("t6_busy_b", 32'(busy_b), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_read_drop", 32'(b_if.mem_read), 32'd0);
      chk("t6_busy_b_drop", 32'(busy_b), 32'd0);
      q_b.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t6_no_resp_b", 32'(b_if.resp_valid), 32'd0);
      end
      chk("t6_ready_b", 32'(b_if.req_ready), 32'd1);

      // reset during WRITE
      issue(0, 1'b1, 19'd5, 19'h00777, 19'h0, 1'b0, 1);
      #2;
      chk("t6_write_active", 32'(a_if.mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_write_drop", 32'(a_if.mem_write), 32'd0);
      chk("t6_addr_drop", 32'(a_if.mem_address), 32'd0);
      q_a.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_resp_a", 32'(a_if.resp_valid), 32'd0);
      end
      chk("t6_ready_a", 32'(a_if.req_ready), 32'd1);
      issue(0, 1'b0, 19'd2, 19'h0, 19'h01A2B, 1'b0, 1);
      drain(0);
      issue(1, 1'b0, 19'd3, 19'h0, 19'h03F4E, 1'b0, 3);
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage sequencer for the 19-bit SELTEN datapath. It sits between execute and Memory_Interface.
- Accepts one load/store request at a time over a valid/ready handshake and drives the single-ported Memory_Interface strobes (mem_read, mem_write, address, write_data).
- Waits the configured read latency, then returns load data or a store acknowledge over a valid/ready response channel.
- Out-of-range addresses are rejected without touching memory.

Parameters:
- DATA_W, 19, data word width
- ADDR_W, 19, address width
- MEM_DEPTH, 1024, number of valid words; any address >= MEM_DEPTH is an error
- READ_LATENCY, 1, cycles mem_read is held before mem_read_data is sampled (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_W  load data (0 for stores and errors)
- resp_error  out  1  address out of range
- mem_read  out  1  to Memory_Interface
- mem_write  out  1  to Memory_Interface
- mem_address  out  ADDR_W  to Memory_Interface
- mem_write_data  out  DATA_W  to Memory_Interface
- mem_read_data  in  DATA_W  from Memory_Interface
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs are 0 except req_ready=1.
  - Internal address, data and counter registers are cleared.
  - Reset mid-operation drops mem_write/mem_read immediately and discards the transaction. No response is issued.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid, the request is accepted at the clock edge: req_addr, req_wdata and req_is_store are registered.
  - If req_addr >= MEM_DEPTH: go to RESP with resp_error=1 and resp_rdata=0. No mem strobe is ever asserted.
  - Otherwise go to WRITE for a store, or to READ for a load with the counter loaded to READ_LATENCY-1.
- WRITE:
  - mem_write=1, mem_address and mem_write_data from the registers, for exactly one cycle.
  - Then go to RESP with resp_rdata=0 and resp_error=0.
- READ:
  - mem_read=1 and mem_address held for READ_LATENCY cycles.
  - Counter decrements each cycle. At counter==0, mem_read_data is captured into resp_rdata and the state goes to RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_error are held stable until resp_ready=1.
  - On the handshake edge, go to IDLE. resp_valid falls the next cycle.
  - req_ready=0 in RESP; no overlap with a new request.
- Strobes:
  - mem_read and mem_write are never high together.
  - Both are low in IDLE and RESP.
  - mem_address and mem_write_data are 0 whenever no strobe is active.
- Latency, with resp_ready held high:
  - Store: acceptance edge N, mem_write high in cycle N+1, resp_valid in cycle N+2.
  - Load: resp_valid in cycle N+1+READ_LATENCY.
  - Error: resp_valid in cycle N+1.
- Throughput: with resp_ready=1, the next request can be accepted one cycle after the response handshake.
- Widths:
  - Address compare is unsigned on ADDR_W bits.
  - The counter is 4 bits.
  - No arithmetic is performed on data.
- Requests presented while req_ready=0 are ignored. The upstream stage holds them until accepted.

Decomposition:
- Shared package selten_pkg holds:
  - DATA_W=19 and ADDR_W=19 constants
  - the lsu state enum (IDLE/WRITE/READ/RESP)
  - the MEM_DEPTH default
- A single module; no sub-module is natural. The latency counter and FSM stay inline.

Test Plan:
1. Reset, then store addr 2 / data 0x1A2B: req_ready=1 before acceptance; mem_write=1 for one cycle with address 0x00002 and data 0x01A2B; resp_valid two cycles after acceptance with resp_rdata=0 and resp_error=0.
2. Load addr 2 after test 1: mem_read high for 1 cycle; resp_valid=1 with resp_rdata=0x01A2B two cycles after acceptance.
3. Store 0x3F4E to addr 3, then immediately load addr 3 with READ_LATENCY=3: load resp_valid four cycles after its acceptance with resp_rdata=0x03F4E; mem_read is high exactly 3 cycles.
4. Load addr 0x7FFFF (MEM_DEPTH=1024): mem_read and mem_write stay 0 throughout; resp_valid one cycle after acceptance with resp_error=1 and resp_rdata=0.
5. Load addr 2 with resp_ready held 0 for 3 cycles: resp_valid, resp_rdata=0x01A2B and resp_error stay constant while req_ready=0; the response completes on the first cycle resp_ready=1.
6. Drop rst_n mid-READ (and separately mid-WRITE): mem_read/mem_write fall without waiting for a clock edge; no resp_valid appears; after release req_ready=1 and a fresh load of addr 2 returns 0x01A2B.
